// File: rtl/microtile_arb_pkg.sv
// Shared definitions for the microtile port arbiter: tile width, FSM
// state encoding and a width helper for index signals.
package microtile_arb_pkg;

    localparam int TILE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Bits needed to hold an index in 0..n-1, never less than one bit.
    function automatic int grant_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/microtile_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request found when
// scanning upward from rr_ptr, wrapping modulo NUM_REQ.
module rr_arbiter
    import microtile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [grant_w(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]          grant,
    output logic [grant_w(NUM_REQ)-1:0] grant_idx,
    output logic                        any_valid
);

    localparam int GW = grant_w(NUM_REQ);

    int idx;

    // Scan from the pointer and latch onto the first valid requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && req[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/microtile_port_arbiter.sv
// Time-shares one combinational 8-bit microtile among NUM_REQ clients.
// A granted payload is registered onto tile_ui_in, held for SETTLE_CYCLES
// edges, then tile_uo_out is captured and returned over valid/ready.
module microtile_port_arbiter
    import microtile_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*8-1:0]         req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [7:0]                   rsp_data,
    output logic [7:0]                   tile_ui_in,
    input  logic [7:0]                   tile_uo_out,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int GW    = grant_w(NUM_REQ);
    localparam int CNT_W = grant_w(SETTLE_CYCLES);

    arb_state_e         state;
    arb_state_e         state_nxt;
    logic [GW-1:0]      rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [GW-1:0]      arb_idx;
    logic               arb_any;
    logic               settle_done;
    logic               rsp_hs;
    logic [GW-1:0]      ptr_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

    assign settle_done = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    // Only the granted line may complete the response.
    assign rsp_hs      = rsp_ready[grant_id];
    assign ptr_nxt     = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; RESP always returns to IDLE so accepts get a bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any)     state_nxt = SETTLE;
            SETTLE:  if (settle_done) state_nxt = RESP;
            RESP:    if (rsp_hs)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: accept only while idle.
    always_comb begin
        req_ready = '0;
        busy      = (state != IDLE);
        if (state == IDLE) begin
            req_ready = arb_grant;
        end
    end

    // Transaction registers; tile_ui_in only moves on an accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_ui_in <= '0;
            rsp_data   <= '0;
            rsp_valid  <= '0;
            grant_id   <= '0;
            rr_ptr     <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        tile_ui_in <= req_data[int'(arb_idx)*TILE_W +: TILE_W];
                        grant_id   <= arb_idx;
                        cnt        <= '0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (settle_done) begin
                        rsp_data  <= tile_uo_out;
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp_valid <= '0;
                        rr_ptr    <= ptr_nxt;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                end
            endcase
        end
    end

endmodule
